mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch requester and the data-memory (MEM-stage) requester of the pipelined RV32I core. It keeps one transaction outstanding at a time, with a fixed memory latency. Data accesses have priority, and a bounded starvation counter guarantees fetch progress. It sits between the core's IF/MEM stages and the memory macro, and drives per-requester stall indications back to the pipeline.

## Interface
Parameters:
- ADDR_W, 9, byte address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from issue to read data valid; legal range ≥1
- STARVE_MAX, 3, consecutive fetch losses before fetch is forced to win; legal range ≥1

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  DATA_W  fetch data
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  4  byte enables for stores
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data accepted (1-cycle pulse)
- dm_rvalid  out  1  load data valid, or store done (1-cycle pulse)
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  4  memory byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- stall_if  out  1  if_req && !if_rvalid
- stall_mem  out  1  dm_req && !dm_rvalid

## Operation
FSM states:
- IDLE: no transaction outstanding.
- BUSY_IF: a fetch is outstanding.
- BUSY_DM: a data access is outstanding.

Arbitration:
- Arbitration happens in IDLE, or in the cycle a response completes (back-to-back issue).
- Winner rule: dm_req wins, unless starve_cnt == STARVE_MAX and if_req is asserted, in which case fetch wins.
- Only one requester alone: that requester wins.

Issue cycle:
- mem_en=1. mem_we, mem_be, mem_addr and mem_wdata are driven combinationally from the winner.
- The winner's gnt is pulsed.
- lat_cnt is loaded with MEM_LAT.
- The FSM moves to BUSY_IF or BUSY_DM.
- For a fetch, mem_we=0 and mem_be=4'hF.

Busy:
- lat_cnt decrements each cycle.
- At lat_cnt==1, the owner's rvalid is pulsed and rdata = mem_rdata, passed through combinationally.
- In that same cycle, arbitration runs again. If there is no winner, the FSM returns to IDLE.
- A store also returns dm_rvalid; dm_rdata holds its previous value.

starve_cnt (width clog2(STARVE_MAX+1)):
- Increments, saturating at STARVE_MAX, at every arbitration where both requesters request and data wins.
- Clears when fetch is granted.

Ignored inputs:
- Requests asserted during busy cycles other than the completion cycle are not accepted; the requester keeps holding.
- mem_* strobes are 0 whenever no issue occurs.

## Timing
Reset values:
- All outputs 0, state IDLE, lat_cnt 0, starve_cnt 0.
- Reset mid-transaction drops the outstanding response: no rvalid appears after reset.

Latency:
- Issue at cycle T, rvalid at T+MEM_LAT, next issue possible at T+MEM_LAT.
- Sustained throughput is one access per MEM_LAT cycles.

Handshake and boundary rules:
- The grant cycle is the cycle in which inputs are sampled. Inputs may change in the cycle after gnt.
- Simultaneous requests in IDLE: data granted first, then fetch at T+MEM_LAT (provided data does not re-request and starve_cnt is below STARVE_MAX).
- Simultaneous completion and new requests: the new issue occurs in the completion cycle.
- Deasserting a request before gnt is a protocol violation; the result is undefined.

## Configuration
- Macro ARB_PERF_EN.
- When defined, two extra output ports are added: perf_conflicts[31:0] and perf_if_stall[31:0].
  - perf_conflicts counts arbitrations where both requesters request.
  - perf_if_stall counts cycles with stall_if=1.
  - Both counters wrap modulo 2^32 and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

## Structure
- Shared package arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_DM} arb_state_t
  - typedef enum logic {REQ_IF, REQ_DM} arb_owner_t
  - localparam ARB_BE_ALL = 4'hF
- One sub-module, arb_lat_counter: loadable down-counter producing a done pulse. It is instantiated once and parameterised by MEM_LAT.

## Test plan
All scenarios use MEM_LAT=2 and STARVE_MAX=3.
- Single fetch: if_req, addr 0x010 at T → if_gnt and mem_en at T; if_rvalid at T+2 with if_rdata = mem_rdata (0xDEADBEEF).
- Simultaneous requests: dm load addr 0x040 and fetch at T → dm_gnt at T; dm_rvalid and if_gnt at T+2; if_rvalid at T+4; stall_if high T..T+3.
- Starvation: dm_req held continuously with back-to-back loads, if_req held → data granted at T, T+2, T+4; fetch forced at T+6; starve_cnt then 0.
- Store: dm_we=1, be=4'b0011, wdata 0x1234ABCD → mem_we=1, mem_be=0011 at the grant; dm_rvalid at +2; dm_rdata unchanged.
- Reset mid-operation: reset at T+1 after a grant at T → no rvalid at T+2; all outputs 0; the next request is granted normally.
- With ARB_PERF_EN defined: run the simultaneous-requests scenario 5 times → perf_conflicts=5; perf_if_stall equals the counted stall_if cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types for the IF/MEM memory port arbiter.
// Holds the FSM state encoding, the owner tag and the full byte-enable mask.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_IF,
    ARB_BUSY_DM
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_DM
  } arb_owner_t;

  localparam logic [3:0] ARB_BE_ALL = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-macro signals of the arbiter.
// slave is the arbiter side; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [3:0]        dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  stall_if, stall_mem
  );

endinterface

// File: rtl/arb_lat_counter.sv
// arb_lat_counter: loadable down-counter timing one memory access.
// done is high in the cycle the response is due (count == 1).
module arb_lat_counter #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int W = $clog2(LAT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding arbiter of fetch and data onto one memory.
// Build with ARB_PERF_EN to add perf_conflicts and perf_if_stall counters.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0] perf_conflicts,
  output logic [31:0] perf_if_stall
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  arb_owner_t        win;
  logic [SW-1:0]     starve;
  logic              dm_st;
  logic              done;
  logic              arb;
  logic              both;
  logic              issue;
  logic              if_rv;
  logic              dm_rv;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  arb_lat_counter #(
    .LAT (MEM_LAT)
  ) u_lat (
    .clk   (clk),
    .reset (reset),
    .load  (issue),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    win            = REQ_DM;
    addr_w         = '0;
    bus.if_gnt     = 1'b0;
    bus.if_rvalid  = 1'b0;
    bus.if_rdata   = '0;
    bus.dm_gnt     = 1'b0;
    bus.dm_rvalid  = 1'b0;
    bus.dm_rdata   = '0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_be     = '0;
    bus.mem_wdata  = '0;
    bus.stall_if   = 1'b0;
    bus.stall_mem  = 1'b0;
    both  = bus.if_req && bus.dm_req;
    arb   = (state == ARB_IDLE) || done;
    issue = !reset && arb && (bus.if_req || bus.dm_req);
    if_rv = !reset && (state == ARB_BUSY_IF) && done;
    dm_rv = !reset && (state == ARB_BUSY_DM) && done;
    // fetch only beats a pending data access once it has lost STARVE_MAX times
    if (bus.if_req && (!bus.dm_req || starve == SW'(STARVE_MAX)))
      win = REQ_IF;
    if (arb) begin
      if (!issue)            state_nxt = ARB_IDLE;
      else if (win == REQ_IF) state_nxt = ARB_BUSY_IF;
      else                   state_nxt = ARB_BUSY_DM;
    end
    if (!reset) begin
      bus.if_rvalid = if_rv;
      bus.dm_rvalid = dm_rv;
      bus.if_rdata  = if_rv ? bus.mem_rdata : if_rdata_q;
      bus.dm_rdata  = (dm_rv && !dm_st) ? bus.mem_rdata : dm_rdata_q;
      bus.stall_if  = bus.if_req && !if_rv;
      bus.stall_mem = bus.dm_req && !dm_rv;
    end
    if (issue) begin
      bus.mem_en = 1'b1;
      unique case (win)
        REQ_IF: begin
          bus.if_gnt = 1'b1;
          bus.mem_be = ARB_BE_ALL;
          addr_w     = bus.if_addr;
        end
        REQ_DM: begin
          bus.dm_gnt    = 1'b1;
          bus.mem_we    = bus.dm_we;
          bus.mem_be    = bus.dm_be;
          bus.mem_wdata = bus.dm_wdata;
          addr_w        = bus.dm_addr;
        end
      endcase
    end
    bus.mem_addr = addr_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve     <= '0;
      dm_st      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (issue) begin
        dm_st <= (win == REQ_DM) && bus.dm_we;
        if (win == REQ_IF)
          starve <= '0;
        else if (both && starve != SW'(STARVE_MAX))
          starve <= starve + SW'(1);
      end
      if (if_rv)
        if_rdata_q <= bus.mem_rdata;
      // a store completion keeps the last load data visible
      if (dm_rv && !dm_st)
        dm_rdata_q <= bus.mem_rdata;
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflicts <= '0;
      perf_if_stall  <= '0;
    end else begin
      if (arb && both)
        perf_conflicts <= perf_conflicts + 32'd1;
      if (bus.stall_if)
        perf_if_stall <= perf_if_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios checked every cycle against a
// timestamp-based model of the arbitration rules, plus literal event checks.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

`ifdef ARB_PERF_EN
  logic [31:0] perf_conflicts;
  logic [31:0] perf_if_stall;
`endif

  mem_port_arbiter #(
    .ADDR_W     (9),
    .DATA_W     (32),
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef ARB_PERF_EN
    ,
    .perf_conflicts (perf_conflicts),
    .perf_if_stall  (perf_if_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int if_gnts[$];
  int dm_gnts[$];
  int if_rvs[$];
  int dm_rvs[$];
  logic [31:0] if_rv_data;
  logic [31:0] dm_rv_data;
  logic        rec_we;
  logic [3:0]  rec_be;
  logic [8:0]  rec_addr;
  logic [31:0] rec_wd;
  int          stall_seen;
  int          stall_total;
  bit          rst_nz;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    if_gnts.delete();
    dm_gnts.delete();
    if_rvs.delete();
    dm_rvs.delete();
    stall_seen = 0;
    rst_nz = 1'b0;
  endtask

  // model: one outstanding access remembered by owner and issue cycle
  bit          m_busy;
  bit          m_dm;
  bit          m_st;
  int          m_iss;
  int          m_starve;
  logic [31:0] m_ifh;
  logic [31:0] m_dmh;
  logic [31:0] m_conf;
  logic [31:0] m_stall;

  always @(negedge clk) begin : model
    bit comp, can, fw, iss, bth;
    logic e_ifg, e_dmg, e_ifv, e_dmv, e_en, e_we, e_sif, e_sm;
    logic [3:0]  e_be;
    logic [8:0]  e_ad;
    logic [31:0] e_wd, e_ifd, e_dmd;
`ifdef ARB_PERF_EN
    chk("perf_conflicts", perf_conflicts, m_conf);
    chk("perf_if_stall", perf_if_stall, m_stall);
`endif
    comp = 0; can = 0; fw = 0; iss = 0; bth = 0;
    e_ifg = 0; e_dmg = 0; e_ifv = 0; e_dmv = 0;
    e_en = 0; e_we = 0; e_sif = 0; e_sm = 0;
    e_be = '0; e_ad = '0; e_wd = '0; e_ifd = '0; e_dmd = '0;
    if (!reset) begin
      comp  = m_busy && (cyc == m_iss + MEM_LAT);
      e_ifv = comp && !m_dm;
      e_dmv = comp && m_dm;
      can   = !m_busy || comp;
      bth   = bus.if_req && bus.dm_req;
      fw    = bus.if_req && (!bus.dm_req || m_starve == STARVE_MAX);
      iss   = can && (bus.if_req || bus.dm_req);
      e_ifg = iss && fw;
      e_dmg = iss && !fw;
      e_en  = iss;
      if (e_ifg) begin
        e_be = 4'hF;
        e_ad = bus.if_addr;
      end
      if (e_dmg) begin
        e_we = bus.dm_we;
        e_be = bus.dm_be;
        e_ad = bus.dm_addr;
        e_wd = bus.dm_wdata;
      end
      e_ifd = e_ifv ? bus.mem_rdata : m_ifh;
      e_dmd = (e_dmv && !m_st) ? bus.mem_rdata : m_dmh;
      e_sif = bus.if_req && !e_ifv;
      e_sm  = bus.dm_req && !e_dmv;
    end
    chk("if_gnt", 32'(bus.if_gnt), 32'(e_ifg));
    chk("dm_gnt", 32'(bus.dm_gnt), 32'(e_dmg));
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_ifv));
    chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(e_dmv));
    chk("if_rdata", bus.if_rdata, e_ifd);
    chk("dm_rdata", bus.dm_rdata, e_dmd);
    chk("mem_en", 32'(bus.mem_en), 32'(e_en));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    chk("mem_be", 32'(bus.mem_be), 32'(e_be));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_ad));
    chk("mem_wdata", bus.mem_wdata, e_wd);
    chk("stall_if", 32'(bus.stall_if), 32'(e_sif));
    chk("stall_mem", 32'(bus.stall_mem), 32'(e_sm));
    if (reset) begin
      m_busy = 0; m_dm = 0; m_st = 0; m_starve = 0;
      m_ifh = '0; m_dmh = '0; m_conf = '0; m_stall = '0;
    end else begin
      m_ifh = e_ifd;
      m_dmh = e_dmd;
      if (can && bth) m_conf = m_conf + 32'd1;
      if (e_sif) m_stall = m_stall + 32'd1;
      if (comp) m_busy = 0;
      if (iss) begin
        m_busy = 1;
        m_dm   = !fw;
        m_st   = !fw && bus.dm_we;
        m_iss  = cyc;
        if (fw) m_starve = 0;
        else if (bth && m_starve < STARVE_MAX) m_starve = m_starve + 1;
      end
    end
    if (reset && (bus.if_gnt || bus.dm_gnt || bus.if_rvalid ||
        bus.dm_rvalid || bus.mem_en || bus.stall_if || bus.stall_mem ||
        bus.if_rdata != 0 || bus.dm_rdata != 0 || bus.mem_addr != 0))
      rst_nz = 1'b1;
    if (bus.if_gnt) if_gnts.push_back(cyc);
    if (bus.dm_gnt) begin
      dm_gnts.push_back(cyc);
      rec_we   = bus.mem_we;
      rec_be   = bus.mem_be;
      rec_addr = bus.mem_addr;
      rec_wd   = bus.mem_wdata;
    end
    if (bus.if_rvalid) begin
      if_rvs.push_back(cyc);
      if_rv_data = bus.if_rdata;
    end
    if (bus.dm_rvalid) begin
      dm_rvs.push_back(cyc);
      dm_rv_data = bus.dm_rdata;
    end
    if (bus.stall_if) begin
      stall_seen++;
      stall_total++;
    end
    cyc++;
  end

  task automatic pair(output int t);
    clr();
    t = cyc;
    bus.mem_rdata = 32'hC0DE0001;
    bus.if_req  = 1'b1;
    bus.if_addr = 9'h014;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_be   = 4'hF;
    bus.dm_addr = 9'h040;
    tick();
    bus.dm_req = 1'b0;
    repeat (3) tick();
    bus.if_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int t;
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_be = '0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0;
    stall_total = 0;
    clr();
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_outputs_zero", 32'(rst_nz), 32'd0);
    reset = 1'b0;
    tick();

    // single fetch
    clr();
    t = cyc;
    bus.mem_rdata = 32'hDEADBEEF;
    bus.if_req  = 1'b1;
    bus.if_addr = 9'h010;
    tick();
    bus.if_req = 1'b0;
    repeat (4) tick();
    chk("s1_if_gnt", qat(if_gnts, 0), t);
    chk("s1_if_rvalid", qat(if_rvs, 0), t + 2);
    chk("s1_if_rdata", if_rv_data, 32'hDEADBEEF);

    // simultaneous requests
    pair(t);
    chk("s2_dm_gnt", qat(dm_gnts, 0), t);
    chk("s2_dm_rvalid", qat(dm_rvs, 0), t + 2);
    chk("s2_if_gnt", qat(if_gnts, 0), t + 2);
    chk("s2_if_rvalid", qat(if_rvs, 0), t + 4);
    chk("s2_stall_if_cycles", stall_seen, 4);

    // starvation
    clr();
    t = cyc;
    bus.mem_rdata = 32'h0BADF00D;
    bus.if_req  = 1'b1;
    bus.if_addr = 9'h018;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 9'h044;
    repeat (7) tick();
    bus.if_req = 1'b0;
    repeat (2) tick();
    bus.if_req = 1'b1;
    repeat (2) tick();
    bus.dm_req = 1'b0;
    repeat (2) tick();
    bus.if_req = 1'b0;
    repeat (3) tick();
    chk("s3_if_gnt_n", if_gnts.size(), 2);
    chk("s3_if_forced", qat(if_gnts, 0), t + 6);
    chk("s3_if_gnt2", qat(if_gnts, 1), t + 12);
    chk("s3_dm_gnt_n", dm_gnts.size(), 5);
    chk("s3_dm_gnt0", qat(dm_gnts, 0), t);
    chk("s3_dm_gnt1", qat(dm_gnts, 1), t + 2);
    chk("s3_dm_gnt2", qat(dm_gnts, 2), t + 4);
    chk("s3_dm_gnt3", qat(dm_gnts, 3), t + 8);
    chk("s3_dm_after_clear", qat(dm_gnts, 4), t + 10);

    // load, then store that must not disturb dm_rdata
    bus.mem_rdata = 32'h5555AAAA;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_be   = 4'hF;
    bus.dm_addr = 9'h0C0;
    tick();
    bus.dm_req = 1'b0;
    repeat (2) tick();
    clr();
    t = cyc;
    bus.mem_rdata = 32'hFFFF0000;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_be    = 4'b0011;
    bus.dm_addr  = 9'h080;
    bus.dm_wdata = 32'h1234ABCD;
    tick();
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    repeat (4) tick();
    chk("s4_dm_gnt", qat(dm_gnts, 0), t);
    chk("s4_mem_we", 32'(rec_we), 32'd1);
    chk("s4_mem_be", 32'(rec_be), 32'h3);
    chk("s4_mem_addr", 32'(rec_addr), 32'h080);
    chk("s4_mem_wdata", rec_wd, 32'h1234ABCD);
    chk("s4_dm_rvalid", qat(dm_rvs, 0), t + 2);
    chk("s4_dm_rdata_kept", dm_rv_data, 32'h5555AAAA);

    // reset mid-transaction
    clr();
    t = cyc;
    bus.mem_rdata = 32'h00000077;
    bus.if_req  = 1'b1;
    bus.if_addr = 9'h020;
    tick();
    bus.if_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.dm_req  = 1'b1;
    bus.dm_addr = 9'h048;
    tick();
    bus.dm_req = 1'b0;
    repeat (4) tick();
    chk("s5_if_gnt", qat(if_gnts, 0), t);
    chk("s5_no_if_rvalid", if_rvs.size(), 0);
    chk("s5_rst_outputs_zero", 32'(rst_nz), 32'd0);
    chk("s5_dm_gnt", qat(dm_gnts, 0), t + 3);
    chk("s5_dm_rvalid", qat(dm_rvs, 0), t + 5);

`ifdef ARB_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stall_total = 0;
    tick();
    repeat (5) pair(t);
    chk("perf_conflicts_5", perf_conflicts, 32'd5);
    chk("perf_if_stall_20", perf_if_stall, 32'd20);
    chk("perf_if_stall_seen", perf_if_stall, 32'(stall_total));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
